// File: rtl/nn_seq_pkg.sv
// Shared types and arithmetic helpers for the layer-sequential inference engine.
package nn_seq_pkg;

  typedef enum logic [1:0] {IDLE, MAC, WB, FIN} state_t;

  // Headroom for NODES full-scale products, so the sum never wraps.
  function automatic int acc_width(input int data_w, input int nodes);
    return 2 * data_w + $clog2(nodes);
  endfunction

  // Arithmetic shift (floor) followed by clamp to the signed data_w range.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                   input int frac, input int data_w);
    logic signed [63:0] s, hi, lo;
    s  = acc >>> frac;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/nn_mac.sv
// Signed multiply-accumulate with synchronous clear (clear wins over enable).
module nn_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  assign prod = $signed(a) * $signed(b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  end

endmodule

// File: rtl/neural_network_seq.sv
// Dense-layer inference engine: one shared MAC, ping-pong activation buffers,
// host-loaded weights/inputs and a registered result read port.
module neural_network_seq
  import nn_seq_pkg::*;
#(
  parameter int LAYERS    = 3,
  parameter int NODES     = 4,
  parameter int DATA_W    = 8,
  parameter int FRAC_BITS = 4,
  localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1,
  localparam int NW = (NODES > 1) ? $clog2(NODES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LAYERS-1:0] relu_mask,
  output logic              busy,
  output logic              done,
  input  logic              wr_weight_en,
  input  logic              wr_input_en,
  input  logic [LW-1:0]     wr_layer,
  input  logic [NW-1:0]     wr_node,
  input  logic [NW-1:0]     wr_src,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int CW    = $clog2(NODES + 1);
  localparam int ACC_W = acc_width(DATA_W, NODES);

  state_t state, next_state;

  logic [LW-1:0]     layer;
  logic [NW-1:0]     neuron;
  logic [CW-1:0]     cnt;
  logic              pp;        // destination buffer select; source is ~pp
  logic [LAYERS-1:0] relu_q;
  logic              issue, mac_en, clr, wb;
  logic              last_neuron, last_layer;
  logic [NW-1:0]     idx;
  logic [DATA_W-1:0] rd_w, rd_x, y;
  logic [ACC_W-1:0]  acc;
  logic [63:0]       acc64;

  logic [DATA_W-1:0] w_mem [LAYERS][NODES][NODES];
  logic [DATA_W-1:0] x_mem [NODES];
  logic [DATA_W-1:0] buf0  [NODES];
  logic [DATA_W-1:0] buf1  [NODES];
  logic [DATA_W-1:0] r_mem [NODES];

  assign last_neuron = (neuron == NW'(NODES - 1));
  assign last_layer  = (layer == LW'(LAYERS - 1));
  assign idx         = cnt[NW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    issue      = 1'b0;
    clr        = 1'b0;
    wb         = 1'b0;
    case (state)
      IDLE: if (start) begin
        next_state = MAC;
        clr        = 1'b1;
      end
      MAC: begin
        busy  = 1'b1;
        issue = (cnt < CW'(NODES));
        if (cnt == CW'(NODES)) next_state = WB;
      end
      WB: begin
        busy       = 1'b1;
        wb         = 1'b1;
        clr        = 1'b1;
        next_state = (last_neuron && last_layer) ? FIN : MAC;
      end
      FIN: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Schedule counters; accumulate trails issue by one cycle via mac_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer  <= '0;
      neuron <= '0;
      cnt    <= '0;
      pp     <= 1'b0;
      relu_q <= '0;
      mac_en <= 1'b0;
    end else begin
      mac_en <= issue;
      if (state == IDLE && start) begin
        layer  <= '0;
        neuron <= '0;
        cnt    <= '0;
        pp     <= 1'b0;
        relu_q <= relu_mask;
      end else if (state == MAC) begin
        cnt <= cnt + 1'b1;
      end else if (wb) begin
        cnt <= '0;
        if (!last_neuron) begin
          neuron <= neuron + 1'b1;
        end else begin
          neuron <= '0;
          if (!last_layer) begin
            layer <= layer + 1'b1;
            pp    <= ~pp;
          end
        end
      end
    end
  end

  nn_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (mac_en),
    .a   (rd_w),
    .b   (rd_x),
    .acc (acc)
  );

  always_comb begin
    acc64 = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
    y     = DATA_W'(sat_shift(acc64, FRAC_BITS, DATA_W));
    if (relu_q[layer] && y[DATA_W-1]) y = '0;
  end

  // Host writes are locked out for the whole run; W/X/buffers have no reset.
  always_ff @(posedge clk) begin
    if (!busy && wr_weight_en && int'(wr_layer) < LAYERS &&
        int'(wr_node) < NODES && int'(wr_src) < NODES)
      w_mem[wr_layer][wr_node][wr_src] <= wr_data;
    if (!busy && wr_input_en && int'(wr_src) < NODES)
      x_mem[wr_src] <= wr_data;
    if (issue) begin
      rd_w <= w_mem[layer][neuron][idx];
      rd_x <= (layer == '0) ? x_mem[idx] : (pp ? buf0[idx] : buf1[idx]);
    end
    if (wb && !last_layer) begin
      if (pp) buf1[neuron] <= y;
      else    buf0[neuron] <= y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NODES; i++) r_mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wb && last_layer) r_mem[neuron] <= y;
      rd_data <= (int'(rd_addr) < NODES) ? r_mem[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_neural_network_seq.sv
// Directed-vector bench: result reads go through an expected-value queue
// checked by an independent monitor; run lengths and handshakes checked inline.
module tb_neural_network_seq;
  localparam int L = 2, N = 4, DW = 8, FB = 4;
  localparam int RUN = L * N * (N + 2);

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [L-1:0]  relu_mask = '0;
  logic          busy, done;
  logic          wr_weight_en = 1'b0, wr_input_en = 1'b0;
  logic [0:0]    wr_layer = '0;
  logic [1:0]    wr_node = '0, wr_src = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0, rd_data;

  int checks = 0, failures = 0, done_cnt = 0;
  logic rd_req = 1'b0, rd_pend = 1'b0;
  logic [DW-1:0] exp_q[$];
  string name_q[$];

  neural_network_seq #(.LAYERS(L), .NODES(N), .DATA_W(DW), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst(rst), .start(start), .relu_mask(relu_mask), .busy(busy), .done(done),
    .wr_weight_en(wr_weight_en), .wr_input_en(wr_input_en), .wr_layer(wr_layer),
    .wr_node(wr_node), .wr_src(wr_src), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin : mon
    logic [DW-1:0] e;
    string nm;
    if (done) done_cnt++;
    if (rd_pend) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read: got %0d with nothing expected", $signed(rd_data));
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (rd_data !== e) begin
          failures++;
          $display("FAIL %s: got %0d expected %0d", nm, $signed(rd_data), $signed(e));
        end
      end
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr_w(input int l, input int n, input int s, input int d);
    wr_weight_en = 1'b1; wr_layer = 1'(l); wr_node = 2'(n); wr_src = 2'(s); wr_data = 8'(d);
    tick;
    wr_weight_en = 1'b0;
  endtask

  task automatic wr_x(input int s, input int d);
    wr_input_en = 1'b1; wr_src = 2'(s); wr_data = 8'(d);
    tick;
    wr_input_en = 1'b0;
  endtask

  task automatic load_w(input int l, input int diag, input int off);
    for (int n = 0; n < N; n++)
      for (int s = 0; s < N; s++) wr_w(l, n, s, (n == s) ? diag : off);
  endtask

  task automatic load_x(input int v[N]);
    for (int s = 0; s < N; s++) wr_x(s, v[s]);
  endtask

  task automatic rd(input int a, input int e, input string nm);
    rd_addr = 2'(a); rd_req = 1'b1;
    exp_q.push_back(8'(e));
    name_q.push_back(nm);
    tick;
    rd_req = 1'b0;
  endtask

  task automatic read_all(input int e[N], input string tag);
    for (int a = 0; a < N; a++) rd(a, e[a], $sformatf("%s_r%0d", tag, a));
    tick; tick;
  endtask

  task automatic start_run(input int relu);
    relu_mask = 2'(relu); start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_rise", int'(busy), 1);
  endtask

  task automatic wait_done(input string nm, input int n0);
    int n;
    n = n0;
    while (!done && n < 1000) begin tick; n++; end
    chk(nm, n, RUN);
    tick;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : drv
    int n, dc;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rd(0, 0, "reset_rd");

    // Identity through both layers
    load_w(0, 8'h10, 0); load_w(1, 8'h10, 0);
    load_x('{16, -32, 48, 5});
    start_run(0); wait_done("len_identity", 0);
    read_all('{16, -32, 48, 5}, "identity");

    // ReLU on layer 0 only
    start_run(1); wait_done("len_relu", 0);
    read_all('{16, 0, 48, 5}, "relu");

    // Saturation both directions
    load_w(0, 8'h7F, 8'h7F); load_w(1, 8'h7F, 8'h7F);
    load_x('{8'h7F, 8'h7F, 8'h7F, 8'h7F});
    start_run(0); wait_done("len_sat_pos", 0);
    read_all('{127, 127, 127, 127}, "sat_pos");
    load_x('{-128, -128, -128, -128});
    start_run(0); wait_done("len_sat_neg", 0);
    read_all('{-128, -128, -128, -128}, "sat_neg");

    // Floor on the shift: 0.5 * -3 = -1.5 -> -2
    load_w(0, 0, 0); wr_w(0, 0, 0, 8'h08); load_w(1, 8'h10, 0);
    load_x('{-3, 0, 0, 0});
    start_run(0); wait_done("len_trunc", 0);
    read_all('{-2, 0, 0, 0}, "trunc");

    // Reset ten cycles into a run
    start_run(0);
    repeat (10) tick;
    dc = done_cnt;
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    tick;
    rst = 1'b0;
    read_all('{0, 0, 0, 0}, "midrst");
    chk("midrst_no_done", done_cnt, dc);
    start_run(0); wait_done("len_rerun", 0);
    read_all('{-2, 0, 0, 0}, "rerun");

    // Writes and start ignored while busy; R holds previous run
    load_w(0, 8'h10, 0);
    load_x('{16, -32, 48, 5});
    start_run(0); wait_done("len_prev", 0);
    read_all('{16, -32, 48, 5}, "prev");
    load_x('{32, 16, -16, -1});
    start_run(0);
    n = 0;
    repeat (3) begin tick; n++; end
    start = 1'b1; wr_weight_en = 1'b1; wr_input_en = 1'b1;
    wr_layer = '0; wr_node = '0; wr_src = '0; wr_data = 8'h7F;
    tick; n++;
    start = 1'b0; wr_weight_en = 1'b0; wr_input_en = 1'b0;
    rd(0, 16, "hold_r0"); rd(1, -32, "hold_r1"); rd(2, 48, "hold_r2"); rd(3, 5, "hold_r3");
    n += 4;
    wait_done("len_busy_prot", n);
    read_all('{32, 16, -16, -1}, "busy_prot");

    repeat (3) tick;
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
